// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - shared encodings for the RV32 instruction packer
package rv_enc_pkg;

    typedef enum logic [2:0] {
        IMM_R  = 3'b000,
        IMM_I  = 3'b001,
        IMM_S  = 3'b010,
        IMM_SB = 3'b100
    } imm_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // An immediate fits the 12-bit signed field when bits 31..11 are all copies of bit 11.
    function automatic logic imm_fits12(input logic [31:0] imm);
        return (imm[31:11] == {21{imm[11]}});
    endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32 field packer with range and selector checks
module instr_pack
    import rv_enc_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_err,
    output logic        sel_err
);

    // Place fields per instruction format; out-of-range immediates are truncated, not clamped.
    always_comb begin
        instr     = 32'd0;
        range_err = 1'b0;
        sel_err   = 1'b0;
        case (sel)
            IMM_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            IMM_I: begin
                instr     = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !imm_fits12(imm);
            end
            IMM_S: begin
                instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !imm_fits12(imm);
            end
            IMM_SB: begin
                // Branch offset is already in halfwords, so imm[0] is real offset bit 1.
                instr     = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
                range_err = !imm_fits12(imm);
            end
            default: begin
                sel_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imem_instr_packer.sv
// rtl/imem_instr_packer.sv - burst loader that packs fields into RV32 words for imem
module imem_instr_packer
    import rv_enc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_words,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_instr,
    output logic             busy,
    output logic             done,
    output logic             err_range,
    output logic             err_sel
);

    state_e           state;
    state_e           next_state;
    logic [31:0]      wr_addr;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      pack_instr;
    logic             pack_range_err;
    logic             pack_sel_err;
    logic             accept;
    logic             out_hs;
    logic             burst_start;

    instr_pack u_pack (
        .sel       (in_sel),
        .opcode    (in_opcode),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .imm       (in_imm),
        .instr     (pack_instr),
        .range_err (pack_range_err),
        .sel_err   (pack_sel_err)
    );

    assign accept      = in_valid & in_ready;
    assign out_hs      = out_valid & out_ready;
    assign burst_start = (state == IDLE) & start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: the burst ends once the last word has left the output register.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && (remaining == CNT_W'(1))) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State-decoded outputs; the input side only accepts when the output slot can take a word.
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        in_ready = (state == RUN) && (!out_valid || out_ready);
    end

    // Address/count bookkeeping, one-deep output register and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= 32'd0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_addr  <= 32'd0;
            out_instr <= 32'd0;
            err_range <= 1'b0;
            err_sel   <= 1'b0;
        end else begin
            if (burst_start) begin
                wr_addr   <= base_addr;
                remaining <= num_words;
                err_range <= 1'b0;
                err_sel   <= 1'b0;
            end else if (accept) begin
                wr_addr   <= wr_addr + 32'd4;
                remaining <= remaining - CNT_W'(1);
                err_range <= err_range | pack_range_err;
                err_sel   <= err_sel | pack_sel_err;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_addr  <= wr_addr;
                out_instr <= pack_instr;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_instr_packer.sv
// tb/tb_imem_instr_packer.sv - directed self-checking bench for imem_instr_packer
module tb_imem_instr_packer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  num_words;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_instr;
    logic        busy;
    logic        done;
    logic        err_range;
    logic        err_sel;

    imem_instr_packer #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_instr (out_instr),
        .busy      (busy),
        .done      (done),
        .err_range (err_range),
        .err_sel   (err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_rerr;
        logic        exp_serr;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    int          checks;
    int          failures;
    int          cyc;
    int          hs_cnt;
    int          done_cnt;
    int          exp_done;
    int          last_hs_cyc;
    int          last_done_cyc;
    int          hs_before;
    logic [31:0] exp_addr;
    logic [31:0] sb_addr[$];
    logic [31:0] sb_instr[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Output scoreboard and done-pulse counter, sampled mid-cycle after the bench drives.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (sb_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got addr 0x%08h instr 0x%08h expected none", out_addr, out_instr);
                end else begin
                    check("out_addr", out_addr, sb_addr.pop_front());
                    check("out_instr", out_instr, sb_instr.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic start_burst(input logic [31:0] base, input logic [7:0] n);
        start     = 1'b1;
        base_addr = base;
        num_words = n;
        exp_addr  = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_fields(input vec_t v);
        in_sel    = v.sel;
        in_opcode = v.op;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
    endtask

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        drive_fields(v);
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                sb_addr.push_back(exp_addr);
                sb_instr.push_back(v.exp_instr);
                exp_addr = exp_addr + 32'd4;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #3;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got done_cnt %0d expected %0d", done_cnt, target);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; hs_cnt = 0; done_cnt = 0; exp_done = 0;
        last_hs_cyc = 0; last_done_cyc = 0; exp_addr = 32'd0;

        //            sel     op     f3    f7     rd    rs1   rs2   imm            instr          rerr  serr
        vecs[0] = '{3'b000, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 32'h4031_00B3, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0, 1'b0};
        vecs[2] = '{3'b010, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0000_07FF, 32'h7E31_2FA3, 1'b0, 1'b0};
        vecs[3] = '{3'b100, 7'h63, 3'd1, 7'h00, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFE, 32'hFE31_1EE3, 1'b0, 1'b0};
        vecs[4] = '{3'b001, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0000_0800, 32'h8001_0093, 1'b1, 1'b0};
        vecs[5] = '{3'b001, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'hFFFF_F800, 32'h8001_0093, 1'b0, 1'b0};
        vecs[6] = '{3'b010, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd3, 32'hFFFF_F800, 32'h8031_2023, 1'b0, 1'b0};
        vecs[7] = '{3'b100, 7'h63, 3'd1, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0000_1000, 32'h0031_1063, 1'b1, 1'b0};
        vecs[8] = '{3'b011, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; base_addr = 32'd0; num_words = 8'd0; in_valid = 1'b0;
        in_sel = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0; out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_err_range", err_range, 0);
        check("rst_err_sel", err_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // in_valid in IDLE is ignored.
        in_valid = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("idle_no_out", out_valid, 0);
        @(negedge clk);

        // Table: one single-word burst per vector; error flags checked after each burst.
        for (int i = 0; i < NVEC; i++) begin
            start_burst(32'h1000 + 32'(16 * i), 8'd1);
            #1;
            check("start_err_range_clr", err_range, 0);
            check("start_err_sel_clr", err_sel, 0);
            check("start_busy", busy, 1);
            @(negedge clk);
            send(vecs[i]);
            exp_done++;
            wait_done(exp_done);
            check("vec_err_range", err_range, vecs[i].exp_rerr);
            check("vec_err_sel", err_sel, vecs[i].exp_serr);
            check("vec_idle", busy, 0);
            check("vec_sb_empty", sb_addr.size(), 0);
        end

        // Three-word burst at full rate; done follows the last output by one cycle.
        start_burst(32'h100, 8'd3);
        send(vecs[1]);
        send(vecs[2]);
        send(vecs[3]);
        exp_done++;
        wait_done(exp_done);
        check("burst3_done_timing", last_done_cyc, last_hs_cyc + 1);
        #1;
        check("burst3_done_one_cycle", done, 0);
        check("burst3_sb_empty", sb_addr.size(), 0);
        check("burst3_err_range", err_range, 0);

        // Backpressure mid-burst: output held stable, input stalled, nothing lost.
        hs_before = hs_cnt;
        start_burst(32'h300, 8'd3);
        send(vecs[0]);
        out_ready = 1'b0;
        drive_fields(vecs[2]);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_addr", out_addr, 32'h300);
            check("stall_out_instr", out_instr, vecs[0].exp_instr);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(vecs[2]);
        send(vecs[3]);
        exp_done++;
        wait_done(exp_done);
        check("stall_hs_count", hs_cnt - hs_before, 3);
        check("stall_sb_empty", sb_addr.size(), 0);

        // Zero-length burst: done without any output word.
        hs_before = hs_cnt;
        start_burst(32'h400, 8'd0);
        #1;
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        check("zero_out_valid", out_valid, 0);
        exp_done++;
        wait_done(exp_done);
        #1;
        check("zero_done_low", done, 0);
        check("zero_idle", busy, 0);
        check("zero_hs_count", hs_cnt - hs_before, 0);

        // start during RUN is ignored: addresses continue from the first base.
        hs_before = hs_cnt;
        start_burst(32'h200, 8'd2);
        start = 1'b1; base_addr = 32'h900; num_words = 8'd5;
        @(negedge clk);
        start = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        exp_done++;
        wait_done(exp_done);
        check("ignstart_hs_count", hs_cnt - hs_before, 2);
        check("ignstart_idle", busy, 0);

        // Address wraps past 2^32.
        start_burst(32'hFFFF_FFFC, 8'd2);
        send(vecs[5]);
        send(vecs[6]);
        exp_done++;
        wait_done(exp_done);
        check("wrap_sb_empty", sb_addr.size(), 0);

        // Asynchronous reset mid-burst with a word pending.
        start_burst(32'h500, 8'd3);
        out_ready = 1'b0;
        send(vecs[4]);
        #1;
        check("prerst_out_valid", out_valid, 1);
        check("prerst_err_range", err_range, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_addr", out_addr, 0);
        check("arst_out_instr", out_instr, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err_range", err_range, 0);
        check("arst_in_ready", in_ready, 0);
        sb_addr.delete();
        sb_instr.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start_burst(32'h600, 8'd1);
        send(vecs[0]);
        exp_done++;
        wait_done(exp_done);
        check("postrst_sb_empty", sb_addr.size(), 0);

        repeat (3) @(negedge clk);
        check("total_done_pulses", done_cnt, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
